piso_stream: RTL and testbench
==============================

// Module: piso_stream
// PURPOSE
//  Parametrised parallel-in/serial-out shifter with handshakes on both sides.
//  - Parallel side: accepts a WIDTH-bit word with valid/ready.
//  - Serial side: emits the word one bit per ser_en-qualified cycle, in a
//    selectable bit order, with frame markers.
//  - Supports back-to-back words with no idle gap. Used as the serialiser
//    stage ahead of line drivers and bit-serial links.
// PARAMETERS
//  WIDTH       8  word width in bits (>=2)
//  MSB_FIRST   1  1: load_data[WIDTH-1] leaves first; 0: load_data[0] first
//  IDLE_LEVEL  0  value driven on ser_out when no frame is active
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst          in   1      synchronous reset, active-high
//  load_valid   in   1      load_data holds a word to send
//  load_ready   out  1      block can accept a word this cycle
//  load_data    in   WIDTH  parallel word
//  ser_en       in   1      downstream consumes the current bit this cycle
//  ser_out      out  1      current serial bit
//  ser_valid    out  1      ser_out carries a frame bit
//  frame_start  out  1      high while the first bit of a frame is presented
//  frame_last   out  1      high while the last bit of a frame is presented
//  busy         out  1      frame in progress (== ser_valid)
// BEHAVIOUR
//  - Reset: while rst=1 at a clock edge:
//    - state->IDLE, counter->0, shift reg->0.
//    - Any frame in progress is aborted.
//    - Outputs: ser_out=IDLE_LEVEL, ser_valid=frame_start=frame_last=busy=0.
//    - load_ready=0 while rst is high.
//  - States: IDLE, SHIFT (plus PAR when PISO_PARITY_EN). Registered
//    outputs, except load_ready.
//  - Accept: a word is accepted when load_valid && load_ready at the edge.
//    - The word is captured into the shift register.
//    - The counter is cleared and the state goes to SHIFT.
//    - First bit is on ser_out the next cycle with ser_valid=1, frame_start=1.
//    - Latency: accept edge -> first bit, 1 cycle.
//  - Transfer: a bit is transferred on each edge with ser_valid && ser_en.
//    - The register shifts (toward the output end per MSB_FIRST) and the
//      counter increments.
//    - With ser_en=0, ser_out and all markers hold unchanged (no bit lost).
//  - load_ready = !rst && (IDLE || (final bit presented && ser_en)).
//  - Back-to-back: accept on the final-bit transfer edge -> the next frame's
//    first bit is presented the following cycle. No idle cycle; frame_start
//    follows frame_last directly.
//  - End of frame: final-bit transfer with no accept -> IDLE,
//    ser_out=IDLE_LEVEL, ser_valid=0.
//  - Counter: width $clog2(WIDTH+1). Final data bit when counter==WIDTH-1.
//    Never wraps past the final bit.
//  - load_valid while busy and not on the final-bit transfer: ignored,
//    load_ready=0. The data must be held by the source.
//  - Words shorter than WIDTH are not supported. All WIDTH bits always go out.
// CONFIGURATION
//  - PISO_PARITY_EN defined:
//    - Parity is computed on accept: ^load_data (even parity).
//    - After the WIDTH data bits, state PAR presents one extra bit = that
//      parity, under the same ser_en hold rule.
//    - frame_last marks the parity bit, not data bit WIDTH-1.
//    - load_ready in SHIFT is 0. Back-to-back accept happens on the parity
//      transfer edge.
//  - PISO_PARITY_EN undefined:
//    - No PAR state and no parity logic.
//    - Frames are exactly WIDTH bits; frame_last is on data bit WIDTH-1.
// TESTING
//  1. rst=1 two cycles -> all outputs 0 / IDLE_LEVEL, load_ready=0; rst=0 -> load_ready=1.
//  2. WIDTH=8, MSB_FIRST=1, word 8'hA5, ser_en=1 -> ser_out 1,0,1,0,0,1,0,1.
//     frame_start on bit0, frame_last on bit7, then ser_valid=0.
//  3. MSB_FIRST=0, 8'h01, ser_en toggling 1/0 -> bits 1,0,0,0,0,0,0,0, each
//     held while ser_en=0. Frame spans 16 cycles.
//  4. Words 8'hF0 then 8'h0F, load_valid continuous -> 16 contiguous bits,
//     no gap, load_ready pulses on the final-bit edge only.
//  5. rst asserted at bit 3 of 8'hFF -> next cycle IDLE, ser_valid=0.
//     A fresh word afterwards sends all 8 bits correctly.
//  6. PISO_PARITY_EN, 8'h07 -> 8 data bits then parity 1, frame_last on the
//     9th bit; 8'h03 -> parity 0.

Source files
------------

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with valid/ready load side and ser_en-paced serial side.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_stream #(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(WIDTH);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic             ser_out_reg, ser_out_next;
  logic             valid_reg, valid_next;
  logic             start_reg, start_next;
  logic             last_reg, last_next;
`ifdef PISO_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  // shift_reg holds only the bits still to come; the bit on the wire lives in ser_out_reg.
  logic [WIDTH-1:0] load_rest, reg_rest;
  logic             load_head, reg_head;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign load_head = load_data[WIDTH-1];
      assign load_rest = {load_data[WIDTH-2:0], 1'b0};
      assign reg_head  = shift_reg[WIDTH-1];
      assign reg_rest  = {shift_reg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign load_head = load_data[0];
      assign load_rest = {1'b0, load_data[WIDTH-1:1]};
      assign reg_head  = shift_reg[0];
      assign reg_rest  = {1'b0, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  logic final_bit;
  logic accept;
  logic xfer;

`ifdef PISO_PARITY_EN
  assign final_bit = (state_reg == PAR);
`else
  assign final_bit = (state_reg == SHIFT) && (count_reg == LAST_IDX);
`endif

  assign load_ready = !rst && ((state_reg == IDLE) || (final_bit && ser_en));
  assign accept     = load_valid && load_ready;
  assign xfer       = valid_reg && ser_en;

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    shift_next   = shift_reg;
    ser_out_next = ser_out_reg;
    valid_next   = valid_reg;
    start_next   = start_reg;
    last_next    = last_reg;
`ifdef PISO_PARITY_EN
    parity_next  = parity_reg;
`endif
    if (accept) begin
      state_next   = SHIFT;
      count_next   = '0;
      shift_next   = load_rest;
      ser_out_next = load_head;
      valid_next   = 1'b1;
      start_next   = 1'b1;
      last_next    = 1'b0;
`ifdef PISO_PARITY_EN
      parity_next  = ^load_data;
`endif
    end else if (xfer) begin
      start_next = 1'b0;
      case (state_reg)
        SHIFT: begin
          shift_next = reg_rest;
          if (count_reg == LAST_IDX) begin
            count_next = FULL_CNT;
`ifdef PISO_PARITY_EN
            state_next   = PAR;
            ser_out_next = parity_reg;
            last_next    = 1'b1;
`else
            state_next   = IDLE;
            ser_out_next = IDLE_LEVEL;
            valid_next   = 1'b0;
            last_next    = 1'b0;
`endif
          end else begin
            count_next   = count_reg + CW'(1);
            ser_out_next = reg_head;
`ifdef PISO_PARITY_EN
            last_next    = 1'b0;
`else
            last_next    = ((count_reg + CW'(1)) == LAST_IDX);
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PAR: begin
          state_next   = IDLE;
          ser_out_next = IDLE_LEVEL;
          valid_next   = 1'b0;
          last_next    = 1'b0;
        end
`endif
        default: begin
          state_next = state_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      shift_reg   <= '0;
      ser_out_reg <= IDLE_LEVEL;
      valid_reg   <= 1'b0;
      start_reg   <= 1'b0;
      last_reg    <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      shift_reg   <= shift_next;
      ser_out_reg <= ser_out_next;
      valid_reg   <= valid_next;
      start_reg   <= start_next;
      last_reg    <= last_next;
`ifdef PISO_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  assign ser_out     = ser_out_reg;
  assign ser_valid   = valid_reg;
  assign frame_start = start_reg;
  assign frame_last  = last_reg;
  assign busy        = valid_reg;

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: per-cycle vector table on an MSB-first instance,
// hand-written ser_en hold sequence on an LSB-first instance.
module tb_piso_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid, load_ready, ser_en;
  logic [7:0] load_data;
  logic       ser_out, ser_valid, frame_start, frame_last, busy;

  logic       l_load_valid, l_load_ready, l_ser_en;
  logic [7:0] l_load_data;
  logic       l_ser_out, l_ser_valid, l_frame_start, l_frame_last, l_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  piso_stream #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .ser_en(ser_en), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_start(frame_start), .frame_last(frame_last), .busy(busy)
  );

  piso_stream #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .rst(rst),
    .load_valid(l_load_valid), .load_ready(l_load_ready), .load_data(l_load_data),
    .ser_en(l_ser_en), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
    .frame_start(l_frame_start), .frame_last(l_frame_last), .busy(l_busy)
  );

  typedef struct {
    logic       rst;
    logic       lv;
    logic [7:0] data;
    logic       en;
    logic       rdy;
    logic       out;
    logic       val;
    logic       st;
    logic       lst;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic lv, input logic [7:0] d, input logic en,
                              input logic rdy, input logic o, input logic v, input logic s,
                              input logic l);
    vec_t x;
    x.rst = r; x.lv = lv; x.data = d; x.en = en;
    x.rdy = rdy; x.out = o; x.val = v; x.st = s; x.lst = l;
    vecs.push_back(x);
  endfunction

  // seq lists the expected wire bits in transmission order (seq[7] first).
  // lv/d are driven for the whole frame; only the final bit may accept them.
  function automatic void add_frame(input logic [7:0] seq, input logic par,
                                    input logic lv, input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
`ifdef PISO_PARITY_EN
      add(1'b0, lv, d, 1'b1, 1'b0, seq[7-i], 1'b1, (i == 0), 1'b0);
`else
      add(1'b0, lv, d, 1'b1, (i == 7), seq[7-i], 1'b1, (i == 0), (i == 7));
`endif
    end
`ifdef PISO_PARITY_EN
    add(1'b0, lv, d, 1'b1, 1'b1, par, 1'b1, 1'b0, 1'b1);
`else
    if (par) begin end
`endif
  endfunction

  task automatic check(input string name, input int idx, input logic [5:0] got,
                       input logic [5:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[%0d] {ready,out,valid,start,last,busy} got %b required %b",
               name, idx, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_data = 8'h00; ser_en = 1'b0;
    l_load_valid = 1'b0; l_load_data = 8'h00; l_ser_en = 1'b0;

    // reset held two cycles, then released
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 0, 0);
    // 8'hA5 MSB first
    add(0, 1, 8'hA5, 1, 1, 0, 0, 0, 0);
    add_frame(8'b10100101, 1'b0, 1'b0, 8'h00);
    add(0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
    // 8'hF0 then 8'h0F back-to-back, load_valid held during the first frame
    add(0, 1, 8'hF0, 1, 1, 0, 0, 0, 0);
    add_frame(8'b11110000, 1'b0, 1'b1, 8'h0F);
    add_frame(8'b00001111, 1'b0, 1'b0, 8'h00);
    add(0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
    // reset during bit 3 of 8'hFF, then a fresh 8'h3C
    add(0, 1, 8'hFF, 1, 1, 0, 0, 0, 0);
    add(0, 0, 8'hFF, 1, 0, 1, 1, 1, 0);
    add(0, 0, 8'hFF, 1, 0, 1, 1, 0, 0);
    add(0, 0, 8'hFF, 1, 0, 1, 1, 0, 0);
    add(1, 0, 8'hFF, 1, 0, 1, 1, 0, 0);
    add(0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
    add(0, 1, 8'h3C, 1, 1, 0, 0, 0, 0);
    add_frame(8'b00111100, 1'b0, 1'b0, 8'h00);
    add(0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
`ifdef PISO_PARITY_EN
    // 8'h07 (parity 1) then 8'h03 (parity 0) accepted on the parity edge
    add(0, 1, 8'h07, 1, 1, 0, 0, 0, 0);
    add_frame(8'b00000111, 1'b1, 1'b1, 8'h03);
    add_frame(8'b00000011, 1'b0, 1'b0, 8'h00);
    add(0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
`endif

    @(posedge clk);
    @(negedge clk);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; load_valid = vecs[i].lv; load_data = vecs[i].data; ser_en = vecs[i].en;
      #1;
      check("msb_vec", i, {load_ready, ser_out, ser_valid, frame_start, frame_last, busy},
            {vecs[i].rdy, vecs[i].out, vecs[i].val, vecs[i].st, vecs[i].lst, vecs[i].val});
      $display("[TB] vec %0d rst=%b lv=%b data=%h en=%b -> rdy=%b out=%b val=%b st=%b last=%b",
               i, rst, load_valid, load_data, ser_en, load_ready, ser_out, ser_valid,
               frame_start, frame_last);
      @(negedge clk);
    end

    // LSB-first 8'h01 with ser_en alternating 0/1: each bit shown for two cycles
    rst = 1'b0; load_valid = 1'b0; ser_en = 1'b0;
    l_load_valid = 1'b1; l_load_data = 8'h01; l_ser_en = 1'b0;
    #1;
    check("lsb_accept", 0, {l_load_ready, l_ser_out, l_ser_valid, l_frame_start, l_frame_last, l_busy},
          6'b100000);
    @(negedge clk);
    l_load_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] word;
      logic       bit_exp;
      int         b;
      word = 8'h01;
      b = k / 2;
      bit_exp = word[b];
      l_ser_en = logic'(k % 2);
      #1;
      check("lsb_hold", k,
            {l_load_ready, l_ser_out, l_ser_valid, l_frame_start, l_frame_last, l_busy},
            {(b == 7) && l_ser_en, bit_exp, 1'b1, (b == 0), (b == 7), 1'b1});
      $display("[TB] lsb cycle %0d en=%b -> out=%b val=%b st=%b last=%b rdy=%b",
               k, l_ser_en, l_ser_out, l_ser_valid, l_frame_start, l_frame_last, l_load_ready);
      @(negedge clk);
    end
    l_ser_en = 1'b0;
    #1;
    check("lsb_end", 0, {l_load_ready, l_ser_out, l_ser_valid, l_frame_start, l_frame_last, l_busy},
          6'b100000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
